rominit_sink: RTL and testbench

ROMINIT_SINK -- requirements
Module: rominit_sink

---
 rtl/scv_pkg.sv | 35 +++
 rtl/rominit_sink.sv | 194 +++++++++++++++++++
 tb/tb_rominit_sink.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scv_pkg.sv
// Shared types and sizes for the ROM-init sink: target encoding,
// loader FSM states and the byte capacity of each target memory.
package scv_pkg;

  typedef enum logic [1:0] {
    TGT_BOOT = 2'd0,
    TGT_CHR  = 2'd1,
    TGT_APU  = 2'd2,
    TGT_CART = 2'd3
  } rominit_target_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FINISH,
    S_REJECT
  } rominit_state_t;

  localparam logic [24:0] BOOT_BYTES = 25'd4096;
  localparam logic [24:0] CHR_BYTES  = 25'd1024;
  localparam logic [24:0] APU_BYTES  = 25'd2048;
  localparam logic [24:0] CART_BYTES = 25'd131072;

  function automatic logic [24:0] tgt_size(input rominit_target_t t);
    logic [24:0] s;
    case (t)
      TGT_BOOT: s = BOOT_BYTES;
      TGT_CHR:  s = CHR_BYTES;
      TGT_APU:  s = APU_BYTES;
      default:  s = CART_BYTES;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rominit_sink.sv
// ROM-init byte sink: steers a byte stream into one of four target
// memories and tracks per-target load status, cart length and errors.
// Ports:
//   CLK, RES                 clock, async active-high reset
//   ROMINIT_SEL_*            target selects (BOOT/CHR/APU/CART)
//   ROMINIT_ADDR/DATA/VALID  byte stream, one byte per VALID cycle
//   WR_ADDR, WR_DATA, *_WE   registered memory write port
//   CART_SIZE                loaded cart length in bytes
//   LOADED                   sticky success flags {CART,APU,CHR,BOOT}
//   CPU_HOLD                 high until BOOT, CHR and APU are loaded
//   ERR                      sticky protocol/range error
module rominit_sink
  import scv_pkg::*;
(
  input  logic        CLK,
  input  logic        RES,
  input  logic        ROMINIT_SEL_BOOT,
  input  logic        ROMINIT_SEL_CHR,
  input  logic        ROMINIT_SEL_APU,
  input  logic        ROMINIT_SEL_CART,
  input  logic [24:0] ROMINIT_ADDR,
  input  logic [7:0]  ROMINIT_DATA,
  input  logic        ROMINIT_VALID,
  output logic [16:0] WR_ADDR,
  output logic [7:0]  WR_DATA,
  output logic        BOOT_WE,
  output logic        CHR_WE,
  output logic        APU_WE,
  output logic        CART_WE,
  output logic [17:0] CART_SIZE,
  output logic [3:0]  LOADED,
  output logic        CPU_HOLD,
  output logic        ERR
);

  rominit_state_t  state_q, state_d;
  rominit_target_t tgt_q, tgt_d;
  logic            valid_q;
  logic [17:0]     cnt_q, cnt_d;
  logic [16:0]     wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [3:0]      we_q, we_d;
  logic [17:0]     cart_size_q, cart_size_d;
  logic [3:0]      loaded_q, loaded_d;
  logic            err_q, err_d;
  logic            hold_q, hold_d;

  logic [3:0]      sel;
  logic            sel_one;
  rominit_target_t sel_tgt;
  logic            rise;
  logic            try_start;
  logic            take;
  logic            fin_ok;
  rominit_target_t use_tgt;
  logic [17:0]     wr_end;

  assign sel = {ROMINIT_SEL_CART, ROMINIT_SEL_APU,
                ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT};
  assign sel_one = (sel != 4'd0) &&
                   ((sel & (sel - 4'd1)) == 4'd0);
  assign rise = ROMINIT_VALID & ~valid_q;
  assign wr_end = {1'b0, wr_addr_q} + 18'd1;

  // Plain case: with several selects high only sel_one gates use.
  always_comb begin
    sel_tgt = TGT_BOOT;
    case (1'b1)
      sel[0]:  sel_tgt = TGT_BOOT;
      sel[1]:  sel_tgt = TGT_CHR;
      sel[2]:  sel_tgt = TGT_APU;
      sel[3]:  sel_tgt = TGT_CART;
      default: sel_tgt = TGT_BOOT;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    we_d        = 4'd0;
    cart_size_d = cart_size_q;
    loaded_d    = loaded_q;
    err_d       = err_q;
    try_start   = 1'b0;
    take        = 1'b0;
    fin_ok      = 1'b0;
    use_tgt     = tgt_q;

    // Cart length follows the write that just went out.
    if (we_q[TGT_CART] && wr_end > cart_size_q)
      cart_size_d = wr_end;

    case (state_q)
      S_IDLE: begin
        if (rise) try_start = 1'b1;
      end
      S_LOAD: begin
        if (ROMINIT_VALID) begin
          take = 1'b1;
          if (sel != (4'b0001 << tgt_q)) err_d = 1'b1;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (tgt_q == TGT_CART)
          fin_ok = (cnt_q != 18'd0);
        else
          fin_ok = (25'(cnt_q) == tgt_size(tgt_q));
        loaded_d[tgt_q] = fin_ok;
        if (!fin_ok) err_d = 1'b1;
        state_d = S_IDLE;
        // VALID may return right after the one low cycle.
        if (rise) try_start = 1'b1;
      end
      default: begin
        if (!ROMINIT_VALID) state_d = S_IDLE;
      end
    endcase

    // The rising VALID cycle already carries the first byte.
    if (try_start) begin
      if (sel_one) begin
        state_d = S_LOAD;
        tgt_d   = sel_tgt;
        use_tgt = sel_tgt;
        cnt_d   = 18'd0;
        loaded_d[sel_tgt] = 1'b0;
        if (sel_tgt == TGT_CART) cart_size_d = 18'd0;
        take    = 1'b1;
      end else begin
        state_d = S_REJECT;
        err_d   = 1'b1;
      end
    end

    if (take) begin
      if (ROMINIT_ADDR < tgt_size(use_tgt)) begin
        we_d      = 4'b0001 << use_tgt;
        wr_addr_d = ROMINIT_ADDR[16:0];
        wr_data_d = ROMINIT_DATA;
        if (cnt_d != 18'h3FFFF) cnt_d = cnt_d + 18'd1;
      end else begin
        err_d = 1'b1;
      end
    end

    hold_d = ~&loaded_d[2:0];
  end

  // valid_q resets high so a VALID held across reset is not a rise.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q     <= S_IDLE;
      tgt_q       <= TGT_BOOT;
      valid_q     <= 1'b1;
      cnt_q       <= 18'd0;
      wr_addr_q   <= 17'd0;
      wr_data_q   <= 8'd0;
      we_q        <= 4'd0;
      cart_size_q <= 18'd0;
      loaded_q    <= 4'd0;
      err_q       <= 1'b0;
      hold_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      valid_q     <= ROMINIT_VALID;
      cnt_q       <= cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      we_q        <= we_d;
      cart_size_q <= cart_size_d;
      loaded_q    <= loaded_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
    end
  end

  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign BOOT_WE   = we_q[0];
  assign CHR_WE    = we_q[1];
  assign APU_WE    = we_q[2];
  assign CART_WE   = we_q[3];
  assign CART_SIZE = cart_size_q;
  assign LOADED    = loaded_q;
  assign CPU_HOLD  = hold_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_rominit_sink.sv
// Directed bench for rominit_sink: per-scenario tasks with inline
// checks against hand-computed values and a latency-1 write model.
module tb_rominit_sink;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        SB = 1'b0, SH = 1'b0, SA = 1'b0, SC = 1'b0;
  logic [24:0] ADDR = '0;
  logic [7:0]  DATA = '0;
  logic        VALID = 1'b0;
  logic [16:0] WR_ADDR;
  logic [7:0]  WR_DATA;
  logic        BOOT_WE, CHR_WE, APU_WE, CART_WE;
  logic [17:0] CART_SIZE;
  logic [3:0]  LOADED;
  logic        CPU_HOLD, ERR;

  int total = 0;
  int bad = 0;

  rominit_sink dut (
    .CLK(CLK), .RES(RES),
    .ROMINIT_SEL_BOOT(SB), .ROMINIT_SEL_CHR(SH),
    .ROMINIT_SEL_APU(SA), .ROMINIT_SEL_CART(SC),
    .ROMINIT_ADDR(ADDR), .ROMINIT_DATA(DATA),
    .ROMINIT_VALID(VALID),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .BOOT_WE(BOOT_WE), .CHR_WE(CHR_WE),
    .APU_WE(APU_WE), .CART_WE(CART_WE),
    .CART_SIZE(CART_SIZE), .LOADED(LOADED),
    .CPU_HOLD(CPU_HOLD), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Write model: a byte seen between edges must appear as a write
  // on the output half a cycle after the next edge.
  logic        exp_active = 1'b0;
  int          exp_tgt = 0;
  logic [3:0]  pend_we = '0;
  logic [16:0] pend_addr = '0;
  logic [7:0]  pend_data = '0;
  int          we_cnt = 0;
  int          mon_bad = 0;

  function automatic int sz(input int t);
    case (t)
      0: return 4096;
      1: return 1024;
      2: return 2048;
      default: return 131072;
    endcase
  endfunction

  always @(negedge CLK) begin
    logic [3:0] we;
    we = {CART_WE, APU_WE, CHR_WE, BOOT_WE};
    if (RES) begin
      pend_we = '0;
    end else begin
      if (we != 4'd0) we_cnt++;
      if (we !== pend_we) mon_bad++;
      else if (pend_we != 4'd0 &&
               (WR_ADDR !== pend_addr || WR_DATA !== pend_data))
        mon_bad++;
      pend_we = '0;
      if (exp_active && VALID && int'(ADDR) < sz(exp_tgt)) begin
        pend_we   = 4'b0001 << exp_tgt;
        pend_addr = ADDR[16:0];
        pend_data = DATA;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] s, input int n,
                       input int seed);
    {SC, SA, SH, SB} = s;
    for (int i = 0; i < n; i++) begin
      ADDR  = 25'(i);
      DATA  = 8'(i ^ seed);
      VALID = 1'b1;
      @(posedge CLK);
      #1;
    end
    VALID = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] we;
    RES = 1'b1;
    idle(3);
    RES = 1'b0;
    idle(1);
    we = {CART_WE, APU_WE, CHR_WE, BOOT_WE};
    total++;
    if (we !== 4'd0 || WR_ADDR !== 17'd0 || WR_DATA !== 8'd0) begin
      bad++;
      $display("FAIL reset_wr we=%b addr=%0d data=%0d req=0/0/0",
               we, WR_ADDR, WR_DATA);
    end
    total++;
    if (CART_SIZE !== 18'd0 || LOADED !== 4'd0) begin
      bad++;
      $display("FAIL reset_state cart=%0d loaded=%b req=0/0000",
               CART_SIZE, LOADED);
    end
    total++;
    if (ERR !== 1'b0 || CPU_HOLD !== 1'b1) begin
      bad++;
      $display("FAIL reset_flags err=%b hold=%b req=0/1",
               ERR, CPU_HOLD);
    end
  endtask

  task automatic test_boot;
    int w0, b0;
    w0 = we_cnt;
    b0 = mon_bad;
    exp_tgt = 0;
    exp_active = 1'b1;
    drive(4'b0001, 4096, 8'h3C);
    idle(3);
    total++;
    if (we_cnt - w0 !== 4096) begin
      bad++;
      $display("FAIL boot_we got=%0d req=4096", we_cnt - w0);
    end
    total++;
    if (mon_bad !== b0) begin
      bad++;
      $display("FAIL boot_wr got=%0d req=0", mon_bad - b0);
    end
    total++;
    if (LOADED !== 4'b0001 || ERR !== 1'b0 || CPU_HOLD !== 1'b1) begin
      bad++;
      $display("FAIL boot_flags loaded=%b err=%b hold=%b req=0001/0/1",
               LOADED, ERR, CPU_HOLD);
    end
  endtask

  task automatic test_hold;
    int b0;
    b0 = mon_bad;
    exp_tgt = 1;
    drive(4'b0010, 1024, 8'hA5);
    idle(3);
    total++;
    if (LOADED !== 4'b0011 || CPU_HOLD !== 1'b1) begin
      bad++;
      $display("FAIL chr_load loaded=%b hold=%b req=0011/1",
               LOADED, CPU_HOLD);
    end
    exp_tgt = 2;
    drive(4'b0100, 2048, 8'h17);
    idle(1);
    total++;
    if (CPU_HOLD !== 1'b1) begin
      bad++;
      $display("FAIL hold_early got=%b req=1", CPU_HOLD);
    end
    idle(1);
    total++;
    if (CPU_HOLD !== 1'b0) begin
      bad++;
      $display("FAIL hold_fall got=%b req=0", CPU_HOLD);
    end
    idle(2);
    total++;
    if (LOADED !== 4'b0111 || ERR !== 1'b0 || mon_bad !== b0) begin
      bad++;
      $display("FAIL apu_load loaded=%b err=%b wrbad=%0d req=0111/0/0",
               LOADED, ERR, mon_bad - b0);
    end
  endtask

  task automatic test_cart;
    int b0;
    b0 = mon_bad;
    exp_tgt = 3;
    drive(4'b1000, 40000, 8'h77);
    idle(3);
    total++;
    if (CART_SIZE !== 18'd40000 || LOADED !== 4'b1111) begin
      bad++;
      $display("FAIL cart_40k size=%0d loaded=%b req=40000/1111",
               CART_SIZE, LOADED);
    end
    drive(4'b1000, 8192, 8'h42);
    idle(3);
    total++;
    if (CART_SIZE !== 18'd8192) begin
      bad++;
      $display("FAIL cart_8k size=%0d req=8192", CART_SIZE);
    end
    total++;
    if (LOADED !== 4'b1111 || ERR !== 1'b0 || mon_bad !== b0) begin
      bad++;
      $display("FAIL cart_flags loaded=%b err=%b wrbad=%0d req=1111/0/0",
               LOADED, ERR, mon_bad - b0);
    end
  endtask

  task automatic test_reject;
    int w0;
    w0 = we_cnt;
    exp_active = 1'b0;
    drive(4'b1001, 16, 8'h11);
    idle(3);
    total++;
    if (we_cnt !== w0) begin
      bad++;
      $display("FAIL reject_we got=%0d req=0", we_cnt - w0);
    end
    total++;
    if (ERR !== 1'b1 || LOADED !== 4'b1111) begin
      bad++;
      $display("FAIL reject_flags err=%b loaded=%b req=1/1111",
               ERR, LOADED);
    end
  endtask

  task automatic test_chr_range;
    int w0, b0;
    w0 = we_cnt;
    b0 = mon_bad;
    exp_tgt = 1;
    exp_active = 1'b1;
    drive(4'b0010, 1030, 8'h5A);
    idle(3);
    total++;
    if (we_cnt - w0 !== 1024 || mon_bad !== b0) begin
      bad++;
      $display("FAIL chr_over we=%0d wrbad=%0d req=1024/0",
               we_cnt - w0, mon_bad - b0);
    end
    total++;
    if (ERR !== 1'b1 || LOADED !== 4'b1111) begin
      bad++;
      $display("FAIL chr_over_flags err=%b loaded=%b req=1/1111",
               ERR, LOADED);
    end
    w0 = we_cnt;
    drive(4'b0010, 1000, 8'h69);
    idle(3);
    total++;
    if (we_cnt - w0 !== 1000) begin
      bad++;
      $display("FAIL chr_short_we got=%0d req=1000", we_cnt - w0);
    end
    total++;
    if (LOADED !== 4'b1101 || ERR !== 1'b1 || CPU_HOLD !== 1'b1) begin
      bad++;
      $display("FAIL chr_short loaded=%b err=%b hold=%b req=1101/1/1",
               LOADED, ERR, CPU_HOLD);
    end
  endtask

  task automatic test_reset_mid;
    int w0, b0;
    logic [3:0] we;
    RES = 1'b1;
    idle(2);
    RES = 1'b0;
    idle(1);
    exp_tgt = 0;
    exp_active = 1'b1;
    {SC, SA, SH, SB} = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      ADDR = 25'(i);
      DATA = 8'(i);
      VALID = 1'b1;
      idle(1);
    end
    ADDR = 25'd100;
    exp_active = 1'b0;
    RES = 1'b1;
    w0 = we_cnt;
    idle(2);
    RES = 1'b0;
    for (int i = 101; i < 107; i++) begin
      ADDR = 25'(i);
      DATA = 8'(i);
      idle(1);
    end
    we = {CART_WE, APU_WE, CHR_WE, BOOT_WE};
    total++;
    if (we_cnt !== w0 || we !== 4'd0) begin
      bad++;
      $display("FAIL rst_mid_we pulses=%0d we=%b req=0/0000",
               we_cnt - w0, we);
    end
    total++;
    if (WR_ADDR !== 17'd0 || WR_DATA !== 8'd0 ||
        CART_SIZE !== 18'd0 || LOADED !== 4'd0 ||
        ERR !== 1'b0 || CPU_HOLD !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_out a=%0d d=%0d c=%0d l=%b e=%b h=%b req=0/0/0/0000/0/1",
               WR_ADDR, WR_DATA, CART_SIZE, LOADED, ERR, CPU_HOLD);
    end
    VALID = 1'b0;
    idle(1);
    w0 = we_cnt;
    b0 = mon_bad;
    exp_active = 1'b1;
    drive(4'b0001, 4096, 8'hC3);
    idle(3);
    total++;
    if (we_cnt - w0 !== 4096 || mon_bad !== b0) begin
      bad++;
      $display("FAIL rst_reload we=%0d wrbad=%0d req=4096/0",
               we_cnt - w0, mon_bad - b0);
    end
    total++;
    if (LOADED !== 4'b0001 || ERR !== 1'b0) begin
      bad++;
      $display("FAIL rst_reload_flags loaded=%b err=%b req=0001/0",
               LOADED, ERR);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_hold();
    test_cart();
    test_reject();
    test_chr_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
